// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: valid/ready payload stage with flush,
// optional 2-entry skid buffer (registered in_ready) and saturating perf counters.
//
// Skid-mode states:
//   state | meaning
//   EMPTY | main register invalid, in_ready=1
//   ONE   | main register valid, skid invalid, in_ready=1
//   TWO   | main and skid valid, in_ready=0
module pipe_stage_reg #(
    parameter int PAYLOAD_W     = 128,
    parameter int SKID          = 1,
    parameter int ZERO_ON_FLUSH = 1,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

            state_t               state;
            logic                 rdy_q;
            logic [PAYLOAD_W-1:0] m_data;
            logic [PAYLOAD_W-1:0] s_data;
            logic                 in_xfer;
            logic                 out_xfer;

            assign in_xfer  = in_valid & rdy_q;
            assign out_xfer = (state != EMPTY) & out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state  <= EMPTY;
                    rdy_q  <= 1'b1;
                    m_data <= '0;
                    s_data <= '0;
                end else if (flush) begin
                    state <= EMPTY;
                    rdy_q <= 1'b1;
                    if (ZERO_ON_FLUSH != 0) begin
                        m_data <= '0;
                        s_data <= '0;
                    end
                end else begin
                    case (state)
                        EMPTY: begin
                            if (in_xfer) begin
                                m_data <= in_data;
                                state  <= ONE;
                            end
                        end
                        ONE: begin
                            if (in_xfer && out_xfer) begin
                                m_data <= in_data;
                            end else if (in_xfer) begin
                                s_data <= in_data;
                                state  <= TWO;
                                rdy_q  <= 1'b0;
                            end else if (out_xfer) begin
                                state <= EMPTY;
                            end
                        end
                        TWO: begin
                            // in_ready is low here, so only the drain case matters
                            if (out_xfer) begin
                                m_data <= s_data;
                                state  <= ONE;
                                rdy_q  <= 1'b1;
                            end
                        end
                        default: begin
                            state <= EMPTY;
                            rdy_q <= 1'b1;
                        end
                    endcase
                end
            end

            assign in_ready  = rdy_q;
            assign out_valid = (state != EMPTY);
            assign out_data  = m_data;
        end else begin : g_single
            logic                 valid_q;
            logic [PAYLOAD_W-1:0] m_data;
            logic                 in_xfer;
            logic                 out_xfer;

            assign in_ready = out_ready | ~valid_q;
            assign in_xfer  = in_valid & in_ready;
            assign out_xfer = valid_q & out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    m_data  <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                    if (ZERO_ON_FLUSH != 0) begin
                        m_data <= '0;
                    end
                end else if (in_xfer) begin
                    m_data  <= in_data;
                    valid_q <= 1'b1;
                end else if (out_xfer) begin
                    valid_q <= 1'b0;
                end
            end

            assign out_valid = valid_q;
            assign out_data  = m_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (!out_valid && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
